// File: rtl/alu_pkg.sv
// alu_pkg -- constants shared by the ALU and its requester-side sequencer.
//
// Holds the 3-bit opcode encoding, the operand/result widths and the
// result-FIFO entry layout. Optional build macro: ALU_SEQ_FLAGS_EN adds
// zero/carry flag bits to each FIFO entry. Without it an entry is
// {op, y}, 19 bits wide.
package alu_pkg;

    localparam int ALU_W_IN  = 8;
    localparam int ALU_W_OUT = 16;

    localparam logic [2:0] ALU_OP_ADD  = 3'd0;
    localparam logic [2:0] ALU_OP_SUB  = 3'd1;
    localparam logic [2:0] ALU_OP_NOT  = 3'd2;
    localparam logic [2:0] ALU_OP_MUL  = 3'd3;
    localparam logic [2:0] ALU_OP_AND  = 3'd4;
    localparam logic [2:0] ALU_OP_OR   = 3'd5;
    localparam logic [2:0] ALU_OP_NAND = 3'd6;
    localparam logic [2:0] ALU_OP_XOR  = 3'd7;

    // One result FIFO entry; the flag bits only exist in the flags build.
    typedef struct packed {
        logic [2:0]           op;
`ifdef ALU_SEQ_FLAGS_EN
        logic                 zero;
        logic                 cout;
`endif
        logic [ALU_W_OUT-1:0] y;
    } alu_res_t;

endpackage

// File: rtl/alu.sv
// alu -- combinational 8-bit ALU with a 16-bit result.
//
// Ports:
//   a, b  in  8   operands
//   s     in  3   opcode (alu_pkg ALU_OP_*)
//   y     out 16  result
// Operands are zero-extended to 16 bits before the operation, so sub and
// the inverting ops produce full 16-bit two's-complement / inverted values
// (3-5 = 16'hFFFE, not 8'h0F = 16'hFFF0).
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W_IN-1:0]  a,
    input  logic [ALU_W_IN-1:0]  b,
    input  logic [2:0]           s,
    output logic [ALU_W_OUT-1:0] y
);

    logic [ALU_W_OUT-1:0] ax, bx;

    assign ax = {{(ALU_W_OUT-ALU_W_IN){1'b0}}, a};
    assign bx = {{(ALU_W_OUT-ALU_W_IN){1'b0}}, b};

    always_comb begin
        y = '0;
        case (s)
            ALU_OP_ADD:  y = ax + bx;
            ALU_OP_SUB:  y = ax - bx;
            ALU_OP_NOT:  y = ~ax;
            ALU_OP_MUL:  y = ax * bx;
            ALU_OP_AND:  y = ax & bx;
            ALU_OP_OR:   y = ax | bx;
            ALU_OP_NAND: y = ~(ax & bx);
            ALU_OP_XOR:  y = ax ^ bx;
            default:     y = '0;
        endcase
    end

endmodule

// File: rtl/alu_res_fifo.sv
// alu_res_fifo -- single-clock synchronous FIFO with occupancy count.
//
// Ports:
//   clk, rst_n  clock / async active-low reset (storage cleared too)
//   push        write push_data when not full
//   push_data   W-bit entry
//   pop         drop the head when not empty (ignored on empty)
//   head        W-bit entry at the read pointer (show-ahead)
//   empty       no entries
//   count       occupancy, 0..DEPTH
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module alu_res_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en, full;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer -- requester side of the 8-bit ALU interface.
//
// Accepts {a, b, op} commands over valid/ready, registers them onto the
// ALU inputs, samples the combinational ALU result one clock later and
// queues {op, y} into a result FIFO drained over valid/ready.
// Optional build macro: ALU_SEQ_FLAGS_EN adds res_zero / res_cout, stored
// per FIFO entry alongside the result.
//
// Ports:
//   clk, rst_n            clock / async active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_a, cmd_b, cmd_op  operands and opcode
//   alu_a, alu_b, alu_s   registered drive into the ALU
//   alu_y                 ALU result (combinational from alu_a/b/s)
//   res_valid/res_ready   result handshake (res_valid = FIFO non-empty)
//   res_data, res_op      FIFO head
//   res_zero, res_cout    FIFO head flags (flags build only)
//   busy                  issue stage occupied or FIFO non-empty
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ALU_W_IN-1:0]  cmd_a,
    input  logic [ALU_W_IN-1:0]  cmd_b,
    input  logic [2:0]           cmd_op,
    output logic [ALU_W_IN-1:0]  alu_a,
    output logic [ALU_W_IN-1:0]  alu_b,
    output logic [2:0]           alu_s,
    input  logic [ALU_W_OUT-1:0] alu_y,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ALU_W_OUT-1:0] res_data,
    output logic [2:0]           res_op,
`ifdef ALU_SEQ_FLAGS_EN
    output logic                 res_zero,
    output logic                 res_cout,
`endif
    output logic                 busy
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int RES_W = $bits(alu_res_t);

    logic             issue_vld;
    logic             accept;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] credit;
    logic             fifo_empty;
    alu_res_t         push_ent, head_ent;
    logic [RES_W-1:0] head_raw;

    // Credit = entries stored + the one in flight. Counting the in-flight
    // issue guarantees its push always finds room; a same-cycle pop only
    // frees credit on the following cycle.
    assign credit    = fifo_cnt + CNT_W'(issue_vld);
    assign cmd_ready = (credit < CNT_W'(FIFO_DEPTH));
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_vld <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
        end else begin
            issue_vld <= accept;
            // Operands hold when idle so the ALU does not toggle.
            if (accept) begin
                alu_a <= cmd_a;
                alu_b <= cmd_b;
                alu_s <= cmd_op;
            end
        end
    end

    // Entry captured from the settled ALU output of the previous issue.
    always_comb begin
        push_ent    = '0;
        push_ent.op = alu_s;
        push_ent.y  = alu_y;
`ifdef ALU_SEQ_FLAGS_EN
        push_ent.zero = (alu_y == '0);
        case (alu_s)
            ALU_OP_ADD: push_ent.cout = alu_y[ALU_W_IN];
            ALU_OP_SUB: push_ent.cout = (alu_a < alu_b);
            default:    push_ent.cout = 1'b0;
        endcase
`endif
    end

    alu_res_fifo #(
        .W     (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue_vld),
        .push_data (push_ent),
        .pop       (res_ready),
        .head      (head_raw),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign head_ent  = alu_res_t'(head_raw);
    assign res_valid = !fifo_empty;
    assign res_data  = head_ent.y;
    assign res_op    = head_ent.op;
`ifdef ALU_SEQ_FLAGS_EN
    assign res_zero  = head_ent.zero;
    assign res_cout  = head_ent.cout;
`endif
    assign busy      = issue_vld || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_a, cmd_b, alu_a, alu_b;
    logic [2:0]  cmd_op, alu_s, res_op;
    logic [15:0] alu_y, res_data;
    logic        res_valid, res_ready, busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic        res_zero, res_cout;
`endif

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
`ifdef ALU_SEQ_FLAGS_EN
        .res_zero  (res_zero),
        .res_cout  (res_cout),
`endif
        .busy      (busy)
    );

    alu u_alu (.a(alu_a), .b(alu_b), .s(alu_s), .y(alu_y));

    typedef struct {
        logic [2:0]  op;
        logic [15:0] y;
        logic        z;
        logic        c;
        int          vis;   // first negedge cycle at which it may be at the head
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_chk = 0, n_pass = 0;
    logic [7:0]  last_a = 0, last_b = 0;
    logic [2:0]  last_s = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: arithmetic on plain integers, truncated to 16 bits.
    function automatic exp_t ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ai = a, bi = b, y = 0;
        case (op)
            3'd0: y = ai + bi;
            3'd1: y = ai - bi;
            3'd2: y = ~ai;
            3'd3: y = ai * bi;
            3'd4: y = ai & bi;
            3'd5: y = ai | bi;
            3'd6: y = ~(ai & bi);
            default: y = ai ^ bi;
        endcase
        e.op  = op;
        e.y   = y[15:0];
        e.z   = (y[15:0] == 16'h0);
        e.c   = (op == 3'd0) ? (ai + bi > 255) : (op == 3'd1) ? (ai < bi) : 1'b0;
        e.vis = 0;
        return e;
    endfunction

    task automatic check_model();
        logic ev;
        chk("cmd_ready", cmd_ready, q.size() < 4);
        chk("busy", busy, q.size() > 0);
        chk("alu_a", alu_a, last_a);
        chk("alu_b", alu_b, last_b);
        chk("alu_s", alu_s, last_s);
        ev = (q.size() > 0) && (q[0].vis <= cyc);
        chk("res_valid", res_valid, ev);
        if (ev) begin
            chk("res_data", res_data, q[0].y);
            chk("res_op", res_op, q[0].op);
`ifdef ALU_SEQ_FLAGS_EN
            chk("res_zero", res_zero, q[0].z);
            chk("res_cout", res_cout, q[0].c);
`endif
        end
    endtask

    // One clock: check at the negedge, then drive and book the handshakes
    // that the next rising edge will perform.
    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic rr, output logic acc);
        exp_t e;
        @(negedge clk);
        check_model();
        cmd_valid = v; cmd_a = a; cmd_b = b; cmd_op = op; res_ready = rr;
        acc = v && cmd_ready;
        if (res_valid && rr && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            e = ref_op(op, a, b);
            e.vis = cyc + 2;
            q.push_back(e);
            last_a = a; last_b = b; last_s = op;
        end
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(0, 0, 0, 0, 1, acc);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic directed(input string tag, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [15:0] y, input logic z, input logic c);
        logic acc;
        cycle(1, a, b, op, 0, acc);
        chk({tag, "_acc"}, acc, 1);
        cycle(0, 0, 0, 0, 0, acc);
        @(negedge clk);
        chk({tag, "_lat"}, res_valid, 1);
        chk({tag, "_y"}, res_data, y);
        chk({tag, "_op"}, res_op, op);
`ifdef ALU_SEQ_FLAGS_EN
        chk({tag, "_z"}, res_zero, z);
        chk({tag, "_c"}, res_cout, c);
`else
        if (z === c) begin end
`endif
        drain();
    endtask

    initial begin
        logic       acc;
        int         k;
        logic [7:0] ba[6], bb[6];
        logic [2:0] bo[6];

        rst_n = 0; cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_op = 0; res_ready = 0;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_op", res_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_alu", {alu_a, alu_b, alu_s}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        directed("add", 3'd0, 8'hFF, 8'h01, 16'h0100, 0, 1);
        directed("sub", 3'd1, 8'h03, 8'h05, 16'hFFFE, 0, 1);
        directed("subz", 3'd1, 8'h05, 8'h05, 16'h0000, 1, 0);
        directed("mul", 3'd3, 8'hFF, 8'hFF, 16'hFE01, 0, 0);
        directed("not", 3'd2, 8'h0F, 8'h00, 16'hFFF0, 0, 0);
        directed("nand", 3'd6, 8'hF0, 8'h3C, 16'hFFCF, 0, 0);

        // Back-to-back stream with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            cycle(1, 8'($urandom), 8'($urandom), 3'($urandom), 1, acc);
            chk("stream_acc", acc, 1);
        end
        drain();

        // Backpressure: consumer stalled, six commands offered.
        for (int i = 0; i < 6; i++) begin
            ba[i] = 8'($urandom); bb[i] = 8'($urandom); bo[i] = 3'($urandom);
        end
        k = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, ba[k], bb[k], bo[k], 0, acc);
            if (acc) k++;
        end
        @(negedge clk);
        chk("bp_accepted", k, 4);
        chk("bp_ready", cmd_ready, 0);
        chk("bp_hold", res_data, q[0].y);
        for (int i = 0; i < 40 && (k < 6 || q.size() > 0); i++) begin
            cycle(k < 6, ba[k % 6], bb[k % 6], bo[k % 6], 1, acc);
            if (acc) k++;
        end
        chk("bp_all_accepted", k, 6);
        chk("bp_all_drained", q.size(), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
                  $urandom_range(0, 9) < 6, acc);
        drain();

        // Reset with a command in flight.
        cycle(1, 8'hAA, 8'h55, 3'd7, 0, acc);
        chk("rst_mid_acc", acc, 1);
        @(negedge clk);
        cmd_valid = 0;
        rst_n = 0;
        #1;
        chk("rst_mid_res_valid", res_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_alu", {alu_a, alu_b, alu_s}, 0);
        q.delete();
        last_a = 0; last_b = 0; last_s = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, acc);
        directed("post_rst_xor", 3'd7, 8'hA5, 8'h0F, 16'h00AA, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
